// File: rtl/rotate_block_scheduler.sv
// ---------------------------------------------------------------------------
// rotate_block_scheduler
//
// Frame-level sequencer for the block address calculator. A frame_start pulse
// selects a frame buffer that the display reader is not holding, then walks
// every 4x4 block coordinate {x,y} into the coordinate FIFO. base_addr_index
// stays stable until the FIFO has drained, after which frame_done pulses.
//
// Configuration macro: TRANSPOSE_SCAN_EN
//   undefined : row-major scan (x advances first)
//   defined   : column-major scan (y advances first), for 90/270 degree reads
//
// Parameters:
//   BLK_X  blocks per row       (1..2047)
//   BLK_Y  block rows per frame (1..2047)
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   frame_start      one-cycle pulse, starts a frame scan
//   rd_buf_index     buffer currently held by the display reader
//   coord_fifo_full  almost-full of the coordinate FIFO (>=1 entry of slack)
//   coord_fifo_empty coordinate FIFO empty flag
//   coord_wr_en      write strobe to the coordinate FIFO
//   coord_data       {x[10:0], y[10:0]}
//   base_addr_index  frame buffer select for the calculator
//   busy             high from buffer selection until the done state exits
//   frame_done       one-cycle pulse once the frame has fully drained
//   frame_overrun    sticky, set by frame_start arriving while busy
// ---------------------------------------------------------------------------
module rotate_block_scheduler #(
    parameter logic [10:0] BLK_X = 11'd480,
    parameter logic [10:0] BLK_Y = 11'd270
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [1:0]  rd_buf_index,
    input  logic        coord_fifo_full,
    input  logic        coord_fifo_empty,
    output logic        coord_wr_en,
    output logic [21:0] coord_data,
    output logic [1:0]  base_addr_index,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_overrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [10:0] x_cnt_r;
    logic [10:0] y_cnt_r;
    logic [10:0] x_nxt_s;
    logic [10:0] y_nxt_s;
    logic        x_last_s;
    logic        y_last_s;
    logic        scan_last_s;
    logic        empty_seen_r;
    logic [1:0]  buf_try_s;
    logic [1:0]  buf_sel_s;

    // Next buffer in rotation, stepping once more if the reader holds it
    always_comb begin
        buf_try_s = base_addr_index + 2'd1;
        if (buf_try_s == rd_buf_index) begin
            buf_sel_s = buf_try_s + 2'd1;
        end else begin
            buf_sel_s = buf_try_s;
        end
    end

    // Scan counter successor; the final coordinate parks both counters at 0
    always_comb begin
        x_last_s    = (x_cnt_r == (BLK_X - 11'd1));
        y_last_s    = (y_cnt_r == (BLK_Y - 11'd1));
        scan_last_s = x_last_s && y_last_s;
        x_nxt_s     = x_cnt_r;
        y_nxt_s     = y_cnt_r;
        if (scan_last_s) begin
            x_nxt_s = 11'd0;
            y_nxt_s = 11'd0;
        end
`ifdef TRANSPOSE_SCAN_EN
        else if (y_last_s) begin
            y_nxt_s = 11'd0;
            x_nxt_s = x_cnt_r + 11'd1;
        end else begin
            y_nxt_s = y_cnt_r + 11'd1;
        end
`else
        else if (x_last_s) begin
            x_nxt_s = 11'd0;
            y_nxt_s = y_cnt_r + 11'd1;
        end else begin
            x_nxt_s = x_cnt_r + 11'd1;
        end
`endif
    end

    // Frame sequencing; drain needs empty seen on two consecutive cycles
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (frame_start) state_nxt_s = S_SELECT;
                else             state_nxt_s = S_IDLE;
            end
            S_SELECT: state_nxt_s = S_RUN;
            S_RUN: begin
                if (!coord_fifo_full && scan_last_s) state_nxt_s = S_DRAIN;
                else                                 state_nxt_s = S_RUN;
            end
            S_DRAIN: begin
                if (coord_fifo_empty && empty_seen_r) state_nxt_s = S_DONE;
                else                                  state_nxt_s = S_DRAIN;
            end
            S_DONE: begin
                // A start landing here is taken as the next frame, not an overrun
                if (frame_start) state_nxt_s = S_SELECT;
                else             state_nxt_s = S_IDLE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            x_cnt_r         <= 11'd0;
            y_cnt_r         <= 11'd0;
            empty_seen_r    <= 1'b0;
            coord_wr_en     <= 1'b0;
            coord_data      <= 22'd0;
            base_addr_index <= 2'd0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            frame_overrun   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            coord_wr_en  <= 1'b0;
            empty_seen_r <= 1'b0;
            busy         <= (state_nxt_s != S_IDLE);
            // frame_done marks the exit of the done state
            frame_done   <= (state_r == S_DONE);
            if (frame_start && (state_r != S_IDLE) && (state_r != S_DONE)) begin
                frame_overrun <= 1'b1;
            end
            case (state_r)
                S_SELECT: begin
                    base_addr_index <= buf_sel_s;
                    x_cnt_r         <= 11'd0;
                    y_cnt_r         <= 11'd0;
                end
                S_RUN: begin
                    // Full is sampled one cycle ahead of the FIFO seeing the write
                    if (!coord_fifo_full) begin
                        coord_wr_en <= 1'b1;
                        coord_data  <= {x_cnt_r, y_cnt_r};
                        x_cnt_r     <= x_nxt_s;
                        y_cnt_r     <= y_nxt_s;
                    end
                end
                S_DRAIN: empty_seen_r <= coord_fifo_empty;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_block_scheduler.sv
module tb_rotate_block_scheduler;

    localparam int BX = 4;
    localparam int BY = 3;
    localparam int NB = BX * BY;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_start = 1'b0;
    logic [1:0]  rd = 2'd0;
    logic        full = 1'b0;
    logic        empty = 1'b1;
    logic        coord_wr_en;
    logic [21:0] coord_data;
    logic [1:0]  base;
    logic        busy;
    logic        frame_done;
    logic        frame_overrun;

    rotate_block_scheduler #(.BLK_X(11'd4), .BLK_Y(11'd3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .rd_buf_index     (rd),
        .coord_fifo_full  (full),
        .coord_fifo_empty (empty),
        .coord_wr_en      (coord_wr_en),
        .coord_data       (coord_data),
        .base_addr_index  (base),
        .busy             (busy),
        .frame_done       (frame_done),
        .frame_overrun    (frame_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int mbase = 0;
    logic [21:0] got[$];
    int wr_full_viol = 0;
    logic full_q = 1'b0;

    // full as seen by the DUT at each rising edge
    always @(posedge clk) full_q <= full;

    // collect FIFO writes between edges
    always @(negedge clk) begin
        if (rst_n && coord_wr_en) begin
            got.push_back(coord_data);
            if (full_q) wr_full_viol <= wr_full_viol + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // k-th coordinate of a frame in scan order
    function automatic logic [21:0] exp_coord(input int k);
        int x;
        int y;
`ifdef TRANSPOSE_SCAN_EN
        y = k % BY;
        x = k / BY;
`else
        x = k % BX;
        y = k / BX;
`endif
        return {x[10:0], y[10:0]};
    endfunction

    function automatic int next_base(input int b, input int r);
        int n;
        n = (b + 1) % 4;
        if (n == r) n = (n + 1) % 4;
        return n;
    endfunction

    // mode: 0 clean, 1 random full/empty, 2 full burst of 5, 3 empty held low, 4 extra start in run
    task automatic run_frame(input int r, input int mode, output int cyc, output int rise);
        int post;
        int hold;
        int bchg;
        logic [1:0] b1;
        got.delete();
        wr_full_viol = 0;
        post = 0; hold = 0; bchg = 0; rise = -1; b1 = 2'd0;
        rd = r[1:0];
        full = 1'b0;
        empty = (mode == 3) ? 1'b0 : 1'b1;
        mbase = next_base(mbase, r);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (frame_done) break;
            if (cyc == 1) begin
                b1 = base;
                chk("busy_in_frame", 32'(busy), 32'd1);
            end else if (base !== b1) begin
                bchg++;
            end
            if (got.size() == NB) post++;
            case (mode)
                1: begin
                    full  = ($urandom_range(0, 3) == 0);
                    empty = ($urandom_range(0, 2) != 0);
                end
                2: begin
                    if (got.size() >= 3 && hold < 5) begin
                        full = 1'b1;
                        hold++;
                    end else begin
                        full = 1'b0;
                    end
                end
                3: begin
                    if (post > 20 && !empty) begin
                        empty = 1'b1;
                        rise = cyc;
                    end
                end
                4: frame_start = (cyc == 5);
                default: ;
            endcase
        end
        full = 1'b0;
        empty = 1'b1;
        frame_start = 1'b0;
        if (!frame_done) chk("frame_done_timeout", 32'd0, 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("base_stable", 32'(bchg), 32'd0);
        chk("base_model", 32'(base), 32'(mbase));
        chk("write_count", 32'(got.size()), 32'(NB));
        for (int k = 0; k < NB && k < got.size(); k++)
            chk($sformatf("coord_%0d", k), 32'(got[k]), 32'(exp_coord(k)));
        chk("write_while_full", 32'(wr_full_viol), 32'd0);
        @(posedge clk); #1;
        chk("done_pulse_width", 32'(frame_done), 32'd0);
    endtask

    typedef struct {
        int         rd_idx;
        logic [1:0] exp_base;
    } buf_vec_t;

    buf_vec_t tab[5];
    int cyc;
    int rise;

    initial begin
        tab[0] = '{2, 2'd3};
        tab[1] = '{0, 2'd1};
        tab[2] = '{0, 2'd2};
        tab[3] = '{0, 2'd3};
        tab[4] = '{0, 2'd1};

        // reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({coord_wr_en, coord_data, base, busy, frame_done, frame_overrun}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic frame: minimum frame time, 0 -> 1
        run_frame(0, 0, cyc, rise);
        chk("basic_frame_time", 32'(cyc), 32'(NB + 4));
        chk("basic_base", 32'(base), 32'd1);
        chk("basic_no_overrun", 32'(frame_overrun), 32'd0);

        // buffer skip table
        for (int i = 0; i < 5; i++) begin
            run_frame(tab[i].rd_idx, 0, cyc, rise);
            chk($sformatf("tab_base_%0d", i), 32'(base), 32'(tab[i].exp_base));
        end

        // backpressure burst costs exactly 5 cycles
        run_frame(3, 2, cyc, rise);
        chk("bp_frame_time", 32'(cyc), 32'(NB + 4 + 5));

        // drain hold: frame_done 3 cycles after empty rises
        run_frame(2, 3, cyc, rise);
        chk("drain_done_delay", 32'(cyc - rise), 32'd3);

        // randomized frames against the model
        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(0, 3)), 1, cyc, rise);
        end
        chk("rand_no_overrun", 32'(frame_overrun), 32'd0);

        // overrun: extra start during run is ignored but flagged
        run_frame(1, 4, cyc, rise);
        chk("overrun_frame_time", 32'(cyc), 32'(NB + 4));
        chk("overrun_set", 32'(frame_overrun), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("overrun_sticky", 32'(frame_overrun), 32'd1);

        // reset mid-scan
        rd = 2'd0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midscan_reset_outputs", 32'({coord_wr_en, coord_data, base, busy, frame_done, frame_overrun}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mbase = 0;
        run_frame(0, 0, cyc, rise);
        chk("post_reset_frame_time", 32'(cyc), 32'(NB + 4));
        chk("post_reset_base", 32'(base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
